// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered DE/HS/VS/pulse decode.
// Optional TIMING_FRAME_CNT_EN adds a 16-bit frame counter output O_frame_cnt.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic        I_pix_clk,
    input  logic        I_rst_n,
    input  logic        I_ce,
    output logic [11:0] O_h_cnt,
    output logic [11:0] O_v_cnt,
    output logic        O_de,
    output logic        O_hs,
    output logic        O_vs,
    output logic [11:0] O_active_x,
    output logic [11:0] O_active_y,
    output logic        O_line_start,
    output logic        O_frame_start
`ifdef TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] O_frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_total
            $error("video_timing_gen: H_TOTAL and V_TOTAL must be in 1..4096");
        end
    endgenerate

    // Bounds are 13 bits so a sync region ending exactly at 4096 still compares correctly.
    localparam logic [12:0] H_ACT_B    = 13'(H_ACTIVE);
    localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_B    = 13'(V_ACTIVE);
    localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
    localparam logic        HS_IDLE    = ~HS_POL;
    localparam logic        VS_IDLE    = ~VS_POL;

    logic [11:0] h_q, h_d, v_q, v_d;
    logic [11:0] h_cnt_q, v_cnt_q, ax_q, ay_q;
    logic [11:0] ax_d, ay_d;
    logic        de_q, hs_q, vs_q, ls_q, fs_q;
    logic        de_d, hs_d, vs_d, ls_d, fs_d;
    logic [12:0] h_ext, v_ext;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (I_ce) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
            end else begin
                h_d = h_q + 12'd1;
            end
        end
    end

    assign h_ext = {1'b0, h_q};
    assign v_ext = {1'b0, v_q};

    always_comb begin
        de_d = (h_ext < H_ACT_B) && (v_ext < V_ACT_B);
        hs_d = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? HS_POL : HS_IDLE;
        vs_d = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? VS_POL : VS_IDLE;
        ax_d = de_d ? h_q : 12'd0;
        ay_d = de_d ? v_q : 12'd0;
        ls_d = (h_q == 12'd0);
        fs_d = (h_q == 12'd0) && (v_q == 12'd0);
    end

    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            de_q    <= 1'b0;
            hs_q    <= HS_IDLE;
            vs_q    <= VS_IDLE;
            ax_q    <= '0;
            ay_q    <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (I_ce) begin
            h_q     <= h_d;
            v_q     <= v_d;
            h_cnt_q <= h_q;
            v_cnt_q <= v_q;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign O_h_cnt       = h_cnt_q;
    assign O_v_cnt       = v_cnt_q;
    assign O_de          = de_q;
    assign O_hs          = hs_q;
    assign O_vs          = vs_q;
    assign O_active_x    = ax_q;
    assign O_active_y    = ay_q;
    assign O_line_start  = ls_q;
    assign O_frame_start = fs_q;

`ifdef TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Advances on the same edge that registers O_frame_start=1.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (I_ce && fs_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign O_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Programmable raster timing generator for the HDMI video path, default 1280x720p60 (74.25 MHz pixel clock). Produces the pixel-domain counters and the DE/HS/VS strobes consumed by the pattern, text and framebuffer generators. It is the timing source those generators align their RGB output to. Pure pixel-clock-domain block with no bus interface.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, horizontal sync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BP, 20, vertical back porch (lines)
HS_POL, 1, HS asserted level (1 = active-high)
VS_POL, 1, VS asserted level (1 = active-high)

Ports:
I_pix_clk  in  1  pixel clock, sole clock
I_rst_n  in  1  asynchronous active-low reset
I_ce  in  1  count enable; 0 freezes all state and outputs
O_h_cnt  out  12  horizontal position, 0..H_TOTAL-1
O_v_cnt  out  12  vertical position, 0..V_TOTAL-1
O_de  out  1  data enable, high in active region
O_hs  out  1  horizontal sync, level per HS_POL
O_vs  out  1  vertical sync, level per VS_POL
O_active_x  out  12  active pixel column; 0 outside the active region
O_active_y  out  12  active line; 0 outside the active region
O_line_start  out  1  one-cycle pulse at h_cnt==0
O_frame_start  out  1  one-cycle pulse at h_cnt==0 and v_cnt==0

Behaviour:
- Clock and reset: single clock I_pix_clk; reset I_rst_n is asynchronous, active-low.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1650). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 750). Both totals must be ≤ 4096; elaborate-time error otherwise.
- Line order is active, front porch, sync, back porch. HS is asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (default 1390..1429). VS is asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (default 725..729), for whole lines from h=0.
- Internal counters h,v:
  - On reset: h=0, v=0.
  - When I_ce=1: h increments, wrapping H_TOTAL-1→0. At that wrap, v increments, wrapping V_TOTAL-1→0.
- Output pipeline: all outputs are registers loaded with the decode of the current internal (h,v). Latency is one cycle, and all outputs are mutually aligned. O_h_cnt/O_v_cnt equal the h/v they describe.
- O_de = (h<H_ACTIVE)&&(v<V_ACTIVE).
- O_active_x = h and O_active_y = v when O_de; otherwise both are 0.
- Reset values:
  - O_h_cnt=0, O_v_cnt=0, O_de=0.
  - O_hs=~HS_POL, O_vs=~VS_POL.
  - O_active_x=0, O_active_y=0.
  - O_line_start=0, O_frame_start=0.
- The first enabled edge after reset release presents (0,0): O_de=1, O_line_start=1, O_frame_start=1.
- I_ce=0: internal counters and every output register hold; pulses stay at their held value. The enable is intended to be held high in normal use.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous). Timing restarts at (0,0) on release.
- No combinational path from any input to any output.

Optional Feature:
Macro TIMING_FRAME_CNT_EN.
- Defined: adds output O_frame_cnt (16 bits), reset 0. It increments on the same edge that registers O_frame_start=1, wraps 65535→0, and holds when I_ce=0. The first frame after reset therefore reads 1.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then release with I_ce=1 → first edge: O_h_cnt=0, O_v_cnt=0, O_de=1, O_frame_start=1, O_hs=0, O_vs=0. Before that edge, all outputs hold reset values.
2. Default params, line 0 → O_de high for exactly 1280 cycles. O_hs high at O_h_cnt=1390..1429 (40 cycles). O_line_start pulses every 1650 cycles.
3. Full frame → O_vs high for exactly 5×1650=8250 cycles starting at O_v_cnt=725, O_h_cnt=0. O_frame_start interval is 1,237,500 cycles. O_de count per frame is 921,600.
4. Small params (H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=0) → H_TOTAL 14, V_TOTAL 7. Sync outputs are active-low. O_active_x=0 at h=8..13. The wrap (13,6)→(0,0) produces O_frame_start.
5. I_ce low for 10 cycles at O_h_cnt=500 → all outputs frozen. Counting resumes at 501 on the first enabled edge.
6. Assert I_rst_n at v=300 mid-line → outputs reset asynchronously. After release, the first frame_start appears on the first edge. With TIMING_FRAME_CNT_EN defined: O_frame_cnt=1 after the first frame start and 0 during reset.
